// File: rtl/game_pkg.sv
// Shared encodings and widths for the bomb game sequencer, countdown and puzzle modules.
package game_pkg;

  localparam int unsigned STATE_W  = 8;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned STRIKE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 8'h00;
  localparam logic [STATE_W-1:0] ST_ACTIVE   = 8'h10;
  localparam logic [STATE_W-1:0] ST_DEFUSED  = 8'h20;
  localparam logic [STATE_W-1:0] ST_EXPLODED = 8'h30;

endpackage

// File: rtl/game_controller_strike_flash.sv
// Retriggerable one-shot: holds strike_led high for FLASH_CYCLES clocks after the last trigger.
module strike_flash #(
  parameter int unsigned FLASH_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic strike_led
);

  localparam int unsigned CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(FLASH_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             led_nxt;

  // Reload on trigger, otherwise count down while lit and go dark after reaching zero.
  always_comb begin
    count_nxt = count;
    led_nxt   = strike_led;
    if (trigger) begin
      count_nxt = LOAD;
      led_nxt   = 1'b1;
    end else if (strike_led) begin
      if (count == '0) begin
        led_nxt = 1'b0;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  // Timer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      strike_led <= 1'b0;
    end else begin
      count      <= count_nxt;
      strike_led <= led_nxt;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Bomb game sequencer: IDLE -> ACTIVE -> DEFUSED/EXPLODED, with strike tally, solve tracking and flash.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_MODULES  = 4,
  parameter int unsigned MAX_STRIKES  = 3,
  parameter int unsigned FLASH_CYCLES = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_MODULES-1:0] module_solved,
  input  logic [NUM_MODULES-1:0] strike,
  input  logic [DIGIT_W-1:0]     value_three,
  input  logic [DIGIT_W-1:0]     value_two,
  input  logic [DIGIT_W-1:0]     value_one,
  output logic [STATE_W-1:0]     game_state,
  output logic [STRIKE_W-1:0]    strike_count,
  output logic [NUM_MODULES-1:0] solved_mask,
  output logic                   strike_led
);

  // Wide enough for strike_count plus a full-vector popcount.
  localparam int unsigned SUM_W = 8;
  localparam logic [SUM_W-1:0]       MAX_SUM    = SUM_W'(MAX_STRIKES);
  localparam logic [STRIKE_W-1:0]    MAX_CNT    = STRIKE_W'(MAX_STRIKES);
  localparam logic [NUM_MODULES-1:0] ALL_SOLVED = '1;
  localparam logic [1:0]             GUARD_MAX  = 2'd2;

  function automatic logic [SUM_W-1:0] popcount(input logic [NUM_MODULES-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      c = c + SUM_W'(v[i]);
    end
    return c;
  endfunction

  logic                   start_q;
  logic [1:0]             guard;
  logic [STATE_W-1:0]     state_nxt;
  logic [STRIKE_W-1:0]    count_nxt;
  logic [NUM_MODULES-1:0] mask_nxt;
  logic [1:0]             guard_nxt;
  logic                   start_rise_c;
  logic [SUM_W-1:0]       strike_n_c;
  logic [SUM_W-1:0]       strike_sum_c;
  logic [NUM_MODULES-1:0] merged_c;
  logic                   timeout_c;
  logic                   flash_trigger_c;

  assign start_rise_c = start & ~start_q;
  assign strike_n_c   = popcount(strike);
  assign strike_sum_c = SUM_W'(strike_count) + strike_n_c;
  assign merged_c     = solved_mask | module_solved;
  // Digits read 999 until the countdown loads, so zero is only trusted once guard saturates.
  assign timeout_c    = (guard == GUARD_MAX) && (value_three == '0) &&
                        (value_two == '0) && (value_one == '0);

  // Next-state and next-value logic for the game sequencer.
  always_comb begin
    state_nxt       = game_state;
    count_nxt       = strike_count;
    mask_nxt        = solved_mask;
    guard_nxt       = guard;
    flash_trigger_c = 1'b0;
    case (game_state)
      ST_IDLE: begin
        if (start_rise_c) begin
          state_nxt = ST_ACTIVE;
          count_nxt = '0;
          mask_nxt  = '0;
          guard_nxt = '0;
        end
      end
      ST_ACTIVE: begin
        mask_nxt        = merged_c;
        count_nxt       = (strike_sum_c >= MAX_SUM) ? MAX_CNT : STRIKE_W'(strike_sum_c);
        guard_nxt       = (guard == GUARD_MAX) ? guard : guard + 2'd1;
        flash_trigger_c = (strike_n_c != '0);
        if ((strike_sum_c >= MAX_SUM) || timeout_c) begin
          state_nxt = ST_EXPLODED;
        end else if (merged_c == ALL_SOLVED) begin
          state_nxt = ST_DEFUSED;
        end
      end
      ST_DEFUSED, ST_EXPLODED: begin
        if (start_rise_c) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
          mask_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
        mask_nxt  = '0;
      end
    endcase
  end

  // Sequencer state, tallies and start edge register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_state   <= ST_IDLE;
      strike_count <= '0;
      solved_mask  <= '0;
      guard        <= '0;
      start_q      <= 1'b0;
    end else begin
      game_state   <= state_nxt;
      strike_count <= count_nxt;
      solved_mask  <= mask_nxt;
      guard        <= guard_nxt;
      start_q      <= start;
    end
  end

  strike_flash #(
    .FLASH_CYCLES(FLASH_CYCLES)
  ) u_strike_flash (
    .clk       (clk),
    .reset     (reset),
    .trigger   (flash_trigger_c),
    .strike_led(strike_led)
  );

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller with a cycle-level behavioural game model.
module tb_game_controller;
  import game_pkg::*;

  localparam int NM = 4;
  localparam int MS = 3;
  localparam int FC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NM-1:0] module_solved = '0;
  logic [NM-1:0] strike = '0;
  logic [3:0]    value_three = 4'd9;
  logic [3:0]    value_two = 4'd9;
  logic [3:0]    value_one = 4'd9;
  logic [7:0]    game_state;
  logic [2:0]    strike_count;
  logic [NM-1:0] solved_mask;
  logic          strike_led;
  logic [15:0]   obs;

  int checks = 0;
  int fails  = 0;

  // Model: phase 0 idle, 1 active, 2 defused, 3 exploded.
  int          m_phase;
  int          m_strikes;
  int          m_age;
  int          m_flash;
  logic [NM-1:0] m_mask;
  logic        m_start_prev;

  game_controller #(.NUM_MODULES(NM), .MAX_STRIKES(MS), .FLASH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .start(start), .module_solved(module_solved),
    .strike(strike), .value_three(value_three), .value_two(value_two),
    .value_one(value_one), .game_state(game_state), .strike_count(strike_count),
    .solved_mask(solved_mask), .strike_led(strike_led)
  );

  always #5 clk = ~clk;

  assign obs = {game_state, strike_count, solved_mask, strike_led};

  function automatic logic [15:0] exp_vec();
    logic [7:0] code;
    case (m_phase)
      0:       code = ST_IDLE;
      1:       code = ST_ACTIVE;
      2:       code = ST_DEFUSED;
      default: code = ST_EXPLODED;
    endcase
    return {code, 3'(m_strikes), m_mask, (m_flash > 0)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_strikes = 0; m_age = 0; m_flash = 0; m_mask = '0; m_start_prev = 1'b0;
  endtask

  // One clock of game rules applied to the inputs currently driven.
  task automatic model_step();
    int   n;
    int   total;
    logic rise;
    logic [NM-1:0] merged;
    logic timeout;
    rise = start && !m_start_prev;
    n = $countones(strike);
    if (m_phase == 1 && n > 0) m_flash = FC;
    else if (m_flash > 0) m_flash = m_flash - 1;
    case (m_phase)
      0: if (rise) begin m_phase = 1; m_strikes = 0; m_mask = '0; m_age = 0; end
      1: begin
        total   = m_strikes + n;
        merged  = m_mask | module_solved;
        timeout = (m_age >= 2) && value_three == 0 && value_two == 0 && value_one == 0;
        m_strikes = (total > MS) ? MS : total;
        m_mask  = merged;
        m_age   = m_age + 1;
        if (total >= MS || timeout) m_phase = 3;
        else if (merged == '1) m_phase = 2;
      end
      default: if (rise) begin m_phase = 0; m_strikes = 0; m_mask = '0; end
    endcase
    m_start_prev = start;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic set_digits(input int d);
    value_three = 4'(d); value_two = 4'(d); value_one = 4'(d);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      $display("FAIL reset_values got=%h exp=%h", obs, 16'h0000); fails++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec()); fails++;
    end
  endtask

  task automatic test_guard_timeout();
    logic [7:0] exp_gs [3];
    exp_gs = '{ST_ACTIVE, ST_ACTIVE, ST_EXPLODED};
    set_digits(0);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (game_state !== ST_ACTIVE) begin
      $display("FAIL guard_enter got=%h exp=%h", game_state, ST_ACTIVE); fails++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (game_state !== exp_gs[i] || obs !== exp_vec()) begin
        $display("FAIL guard_timeout step=%0d got=%h exp_state=%h exp_model=%h",
                 i, obs, exp_gs[i], exp_vec()); fails++;
      end
    end
    pulse_start();
    checks++;
    if (game_state !== ST_IDLE) begin
      $display("FAIL guard_back_idle got=%h exp=%h", game_state, ST_IDLE); fails++;
    end
  endtask

  task automatic test_start_held();
    int transitions;
    logic [7:0] prev;
    transitions = 0;
    set_digits(3);
    start = 1'b1;
    prev = game_state;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (game_state !== prev) transitions++;
      prev = game_state;
      checks++;
      if (obs !== exp_vec()) begin
        $display("FAIL start_held cyc=%0d got=%h exp=%h", i, obs, exp_vec()); fails++;
      end
    end
    checks++;
    if (transitions != 1 || game_state !== ST_ACTIVE) begin
      $display("FAIL start_held_once transitions=%0d state=%h exp_transitions=1 exp_state=%h",
               transitions, game_state, ST_ACTIVE); fails++;
    end
    start = 1'b0;
    strike = 4'b0111; tick(); strike = '0;
    checks++;
    if (game_state !== ST_EXPLODED || obs !== exp_vec()) begin
      $display("FAIL triple_strike got=%h exp=%h", obs, exp_vec()); fails++;
    end
    pulse_start();
  endtask

  task automatic test_strikes();
    int led_cycles;
    set_digits(5);
    repeat (FC + 2) tick();
    pulse_start();
    strike = 4'b0001; tick();
    checks++;
    if (strike_count !== 3'd1 || game_state !== ST_ACTIVE || strike_led !== 1'b1) begin
      $display("FAIL strike_single got=%h exp_count=1 exp_state=10 exp_led=1", obs); fails++;
    end
    strike = 4'b0110; tick(); strike = '0;
    checks++;
    if (strike_count !== 3'd3 || game_state !== ST_EXPLODED || obs !== exp_vec()) begin
      $display("FAIL strike_double got=%h exp=%h", obs, exp_vec()); fails++;
    end
    led_cycles = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (strike_led === 1'b1) led_cycles++;
      checks++;
      if (obs !== exp_vec()) begin
        $display("FAIL strike_flash cyc=%0d got=%h exp=%h", i, obs, exp_vec()); fails++;
      end
    end
    checks++;
    if (led_cycles != FC) begin
      $display("FAIL flash_length got=%0d exp=%0d", led_cycles, FC); fails++;
    end
    pulse_start();
  endtask

  task automatic test_solved();
    logic [NM-1:0] seq    [5];
    logic [NM-1:0] exp_m  [5];
    logic [7:0]    exp_gs [5];
    seq    = '{4'b0001, 4'b0101, 4'b0001, 4'b1001, 4'b1011};
    exp_m  = '{4'b0001, 4'b0101, 4'b0101, 4'b1101, 4'b1111};
    exp_gs = '{ST_ACTIVE, ST_ACTIVE, ST_ACTIVE, ST_ACTIVE, ST_DEFUSED};
    set_digits(4);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      module_solved = seq[i]; tick();
      checks++;
      if (solved_mask !== exp_m[i] || game_state !== exp_gs[i] || obs !== exp_vec()) begin
        $display("FAIL solved_sticky step=%0d got=%h exp_mask=%b exp_state=%h model=%h",
                 i, obs, exp_m[i], exp_gs[i], exp_vec()); fails++;
      end
    end
    module_solved = '0; tick();
    checks++;
    if (solved_mask !== 4'b1111 || game_state !== ST_DEFUSED) begin
      $display("FAIL defused_frozen got=%h exp_mask=1111 exp_state=20", obs); fails++;
    end
    pulse_start();
    checks++;
    if (obs !== exp_vec() || solved_mask !== '0) begin
      $display("FAIL defused_restart got=%h exp=%h", obs, exp_vec()); fails++;
    end
  endtask

  task automatic test_priority();
    set_digits(7);
    pulse_start();
    strike = 4'b0011; module_solved = 4'b0111; tick();
    checks++;
    if (strike_count !== 3'd2 || game_state !== ST_ACTIVE) begin
      $display("FAIL prio_setup got=%h exp_count=2 exp_state=10", obs); fails++;
    end
    strike = 4'b0100; module_solved = 4'b1111; tick();
    checks++;
    if (game_state !== ST_EXPLODED || obs !== exp_vec()) begin
      $display("FAIL explode_beats_defuse got=%h exp=%h", obs, exp_vec()); fails++;
    end
    strike = 4'b1000; module_solved = '0; tick(); strike = '0;
    checks++;
    if (strike_count !== 3'd3 || game_state !== ST_EXPLODED) begin
      $display("FAIL terminal_ignores_strike got=%h exp_count=3 exp_state=30", obs); fails++;
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (game_state !== ST_IDLE || strike_count !== 3'd0 || solved_mask !== '0) begin
      $display("FAIL restart_clears got=%h exp_state=00 exp_count=0 exp_mask=0", obs); fails++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_digits(9);
    pulse_start();
    strike = 4'b0001; tick(); strike = '0;
    checks++;
    if (strike_led !== 1'b1 || game_state !== ST_ACTIVE) begin
      $display("FAIL async_setup got=%h exp_led=1 exp_state=10", obs); fails++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      $display("FAIL async_reset got=%h exp=%h", obs, 16'h0000); fails++;
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      $display("FAIL after_reset got=%h exp=%h", obs, exp_vec()); fails++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 12) == 0;
      for (int b = 0; b < NM; b++) strike[b] = ($urandom % 40) == 0;
      if (($urandom % 6) == 0) module_solved[$urandom % NM] = ~module_solved[$urandom % NM];
      if (($urandom % 25) == 0) set_digits(0);
      else begin
        value_three = 4'($urandom_range(0, 9));
        value_two   = 4'($urandom_range(0, 9));
        value_one   = 4'($urandom_range(0, 9));
      end
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec()); fails++;
      end
    end
    start = 1'b0; strike = '0; module_solved = '0;
  endtask

  initial begin
    test_reset();
    test_guard_timeout();
    test_start_held();
    test_strikes();
    test_solved();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level game sequencer for the bomb puzzle.
- Produces the 8-bit game_state code that the countdown timer and the puzzle modules consume.
- Watches the countdown's three BCD digits for timeout, collects per-module solved flags and strike pulses, and decides the outcome: defused or exploded.
- Also drives a timed strike indicator.

Parameters:
- NUM_MODULES, 4: number of puzzle modules; width of the solved/strike vectors.
- MAX_STRIKES, 3: strike total that forces EXPLODED (1..7).
- FLASH_CYCLES, 25000000: clk cycles strike_led stays high after a strike (0.5 s at 50 MHz).

Ports:
- clk  in  1  on-board 50 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start/acknowledge button, already synchronized and debounced, active-high level.
- module_solved  in  NUM_MODULES  per-module solved level; bit may drop after rising.
- strike  in  NUM_MODULES  per-module single-cycle strike pulses.
- value_three  in  4  countdown hundreds digit (BCD).
- value_two  in  4  countdown tens digit (BCD).
- value_one  in  4  countdown ones digit (BCD).
- game_state  out  8  8'h00 IDLE, 8'h10 ACTIVE, 8'h20 DEFUSED, 8'h30 EXPLODED.
- strike_count  out  3  strikes accumulated this game.
- solved_mask  out  NUM_MODULES  sticky record of modules solved this game.
- strike_led  out  1  high while the strike flash timer runs.

Behaviour:
- Reset (async assert, sync release): game_state=8'h00, strike_count=0, solved_mask=0, strike_led=0. Flash timer, guard counter and start_q are cleared.
- start edge: start_q registers start; start_rise = start & ~start_q. Only rising edges act; a held button never re-triggers.
- IDLE: on start_rise -> ACTIVE next cycle. Entering ACTIVE clears strike_count, solved_mask and the guard counter.
- ACTIVE, guard: a 2-bit guard counter runs 0..2 and saturates. Timeout detection is masked while guard<2, because the countdown needs one ACTIVE cycle to load and its digits read 9/9/9 before that.
- ACTIVE, solved flags: solved_mask |= module_solved every cycle.
- ACTIVE, strikes: n = popcount(strike) per cycle. Simultaneous strikes all count. strike_count = min(strike_count+n, MAX_STRIKES).
- ACTIVE, exits, evaluated on next-cycle values:
  - EXPLODED if (strike_count+n >= MAX_STRIKES), or if (guard==2 and all three digits == 0).
  - Otherwise DEFUSED if (solved_mask | module_solved) is all ones.
  - Otherwise stay ACTIVE.
  - Explosion beats defuse when both hold in the same cycle.
  - start_rise is ignored while ACTIVE.
- DEFUSED / EXPLODED: terminal. solved_mask and strike_count are frozen; strike inputs are ignored. start_rise -> IDLE, which clears strike_count and solved_mask on entry.
- Timeout latency: zero digits seen in cycle t -> game_state=8'h30 at t+1. The countdown holds 000 for at least one sec_timer period, so no zero is missed.
- strike_led:
  - Any strike with n>0 in ACTIVE loads the flash timer with FLASH_CYCLES-1 and sets strike_led=1 next cycle.
  - A strike while flashing reloads the timer (retrigger).
  - strike_led drops the cycle after the timer reaches 0.
  - The timer keeps running across state changes; it is cleared only by reset.
- Illegal encodings: any game_state value outside the four codes recovers to IDLE next cycle.
- Reset mid-game: all outputs return to reset values immediately (async).

Decomposition:
- Shared package game_pkg:
  - constants ST_IDLE=8'h00, ST_ACTIVE=8'h10, ST_DEFUSED=8'h20, ST_EXPLODED=8'h30. The countdown and puzzle modules use the same constants.
  - BCD digit width constant 4.
- One sub-module: strike_flash. It contains the reloadable down-counter producing strike_led, with inputs clk, reset, trigger. The popcount is a local function, not a module.

Test Plan:
- Reset, then start held high 10 cycles -> exactly one IDLE->ACTIVE transition; game_state=8'h10 from cycle 2; no further transitions.
- ACTIVE, digits 0/0/0 on the first ACTIVE cycle -> no explosion (guard masks it). The same digits at guard==2 -> game_state=8'h30 the next cycle.
- MAX_STRIKES=3: strike=4'b0001, then strike=4'b0110 in one cycle -> strike_count 1 then 3; game_state=8'h30 one cycle after the double strike. strike_led high for FLASH_CYCLES (set to 8 in sim) after the last strike.
- module_solved bits rise at different times, bit 2 drops after rising -> solved_mask sticky; 8'h20 one cycle after the last bit rises.
- Final solve and third strike in the same cycle -> 8'h30 (explosion priority). Then start_rise -> 8'h00 with strike_count=0, solved_mask=0.
- Assert reset during ACTIVE with strike_led high -> all outputs 0 asynchronously, before the next clk edge.
